traffic_request_conditioner: RTL and testbench
==============================================

Name: traffic_request_conditioner

Overview:
- Input-side front end for the traffic light controller. It takes raw pedestrian and emergency buttons and the raw 8-bit timing/data switches, and delivers clean, acknowledged requests and a stable data word.
- It acts as the initiator of the request handshake. The controller is the responder and acknowledges each request once it has serviced it.
- Each button request is held until acknowledged, so a 1-cycle press can no longer be missed or double-counted.

Parameters:
- DATA_W, 8: width of data_raw/data_out.
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high cycles (buttons) or unchanged cycles (data) required before acceptance; legal range 1..255.
- COOLDOWN_CYCLES, 8: minimum cycles after an ack before the same channel may re-arm; legal range 1..255.
- TIMEOUT_CYCLES, 64: pending-request timeout; used only with REQ_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ped_raw, input, 1: raw pedestrian button, asynchronous.
- em_raw, input, 1: raw emergency button, asynchronous.
- data_raw, input, DATA_W: raw switch word, asynchronous and slowly changing.
- ped_ack, input, 1: controller acknowledge for ped_req.
- em_ack, input, 1: controller acknowledge for em_req.
- ped_req, output, 1: pedestrian request, held until acknowledged.
- em_req, output, 1: emergency request, held until acknowledged.
- data_out, output, DATA_W: last accepted stable data word.
- data_valid, output, 1: 1-cycle pulse when data_out changes.
- req_timeout, output, 2: {em, ped} timeout pulses. Tied to 0 when REQ_TIMEOUT_EN is undefined.

Behaviour:
- Reset values (asynchronous, while reset=1): all synchronizer flops 0; both channels in IDLE; all counters 0; ped_req=0, em_req=0, data_out=0, data_valid=0, req_timeout=0.
- Synchronization: every raw input passes through 2 flops. Logic uses only the second flop ("s").
- Per-button channel FSM, identical for ped and em, fully independent of each other:
  - IDLE: when s=1, go to DEBOUNCE with cnt=1.
  - DEBOUNCE: when s=0, go to IDLE. When s=1 and cnt==DEBOUNCE_CYCLES, go to PENDING. Otherwise cnt++.
  - PENDING: req=1 (registered, so req is high in every cycle the state is PENDING). When ack=1 is sampled, go to COOLDOWN with cnt=1. req=0 from the following cycle.
  - COOLDOWN: cnt++ until cnt==COOLDOWN_CYCLES. Then go to IDLE only once s=0 (button must be released). Otherwise stay, holding cnt.
- Latency: raw high first sampled at edge E0 → req high after edge E(2+DEBOUNCE_CYCLES). With defaults this is 6 edges.
- Ack in any state other than PENDING is ignored. Ack held high for several cycles counts once.
- Raw glitch shorter than DEBOUNCE_CYCLES → no request.
- Presses during PENDING or COOLDOWN are absorbed: no queueing, no second request.
- Both buttons pressed simultaneously → both req lines rise on the same edge. Priority is the controller's decision.
- Data channel:
  - Compare s_data with the previous cycle's s_data. On a change, stable_cnt=1. Otherwise it saturates at DEBOUNCE_CYCLES.
  - When stable_cnt==DEBOUNCE_CYCLES and s_data != data_out, then on the next edge data_out=s_data and data_valid=1 for exactly 1 cycle.
  - Unchanged stable data never re-pulses data_valid.
  - A word that reverts to the current data_out before it becomes stable produces no pulse.
- Reset asserted mid-operation: immediate return to the reset values above. A pending request is lost, and the controller must not expect an ack to be required.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- Defined: each channel has a timeout counter that counts while in PENDING. If TIMEOUT_CYCLES elapse with no ack:
  - the channel drops req;
  - pulses its req_timeout bit for 1 cycle;
  - enters COOLDOWN.
- Ack on the same edge as the timeout takes precedence: normal COOLDOWN, no timeout pulse.
- Undefined: no timeout counter. Requests are held indefinitely; req_timeout=2'b00.

Decomposition:
- Shared package (traffic_pkg) holds:
  - channel state encoding: IDLE=2'd0, DEBOUNCE=2'd1, PENDING=2'd2, COOLDOWN=2'd3;
  - default constant values for DEBOUNCE_CYCLES, COOLDOWN_CYCLES and TIMEOUT_CYCLES.
- Sub-module request_channel holds the synchronizer, FSM, counters and optional timeout. It is instantiated twice (ped, em).
- The data debounce stays in the top level.

Test Plan:
- Reset release with data_raw=2 held → data_out=2 and data_valid pulses once, 2+DEBOUNCE_CYCLES+1 edges after reset deasserts; no further pulses.
- ped_raw high for 1 cycle → ped_req never asserts. ped_raw high for 10 cycles → ped_req rises 6 edges after the first sample; ack after 3 cycles → ped_req low next cycle.
- em_raw held high through ack and 20 cycles beyond → exactly one em_req; re-arms only after release plus COOLDOWN_CYCLES; a second press then yields a second em_req.
- ped_raw and em_raw rise on the same edge → both reqs rise together; ack em only → ped_req stays high until ped_ack.
- data_raw changes 10→0→5 with each value held 2 cycles, then 20 held 10 cycles → a single data_valid with data_out=20.
- REQ_TIMEOUT_EN defined: no ack for 64 cycles → req drops and req_timeout[0] (ped) pulses once. Reset asserted during PENDING → req=0 immediately, asynchronously.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared channel state encoding and default timing constants for the request conditioner.
package traffic_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PENDING  = 2'd2,
    COOLDOWN = 2'd3
  } chan_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_TIMEOUT_CYCLES  = 64;
endpackage

// File: rtl/request_channel.sv
// request_channel: synchronizes one button, debounces it and holds a request until acknowledged.
// Optional pending-request timeout when REQ_TIMEOUT_EN is defined.
module request_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic ack,
  output logic req,
  output logic timeout
);
  logic s1, s, tmo;
  chan_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= 8'd0;
      req   <= 1'b0;
    end else begin
      s1    <= raw;
      s     <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      req   <= state_n == PENDING;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:
        if (s) begin
          state_n = DEBOUNCE;
          cnt_n   = 8'd1;
        end
      DEBOUNCE:
        if (!s) state_n = IDLE;
        else if (cnt == 8'(DEBOUNCE_CYCLES)) state_n = PENDING;
        else cnt_n = cnt + 8'd1;
      PENDING:
        if (ack || tmo) begin
          state_n = COOLDOWN;
          cnt_n   = 8'd1;
        end
      COOLDOWN:
        if (cnt != 8'(COOLDOWN_CYCLES)) cnt_n = cnt + 8'd1;
        else if (!s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`ifdef REQ_TIMEOUT_EN
  logic [15:0] tcnt;
  // An ack on the expiry edge wins, so the timeout only fires without one.
  assign tmo = state == PENDING && !ack && tcnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt    <= 16'd0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= (state == PENDING && state_n == PENDING) ? tcnt + 16'd1 : 16'd0;
      timeout <= tmo;
    end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner: conditions raw buttons into acknowledged requests and debounces the data switches.
// Define REQ_TIMEOUT_EN to enable the pending-request timeout and req_timeout pulses.
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ped_raw,
  input  logic              em_raw,
  input  logic [DATA_W-1:0] data_raw,
  input  logic              ped_ack,
  input  logic              em_ack,
  output logic              ped_req,
  output logic              em_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [1:0]        req_timeout
);
  request_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ped (
    .clk    (clk),
    .reset  (reset),
    .raw    (ped_raw),
    .ack    (ped_ack),
    .req    (ped_req),
    .timeout(req_timeout[0])
  );
  request_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_em (
    .clk    (clk),
    .reset  (reset),
    .raw    (em_raw),
    .ack    (em_ack),
    .req    (em_req),
    .timeout(req_timeout[1])
  );
  logic [DATA_W-1:0] d1, s_data, prev_data;
  logic [7:0] stable_cnt;
  logic accept;
  // Requiring s_data == prev_data keeps a word that changes on this very edge from slipping through.
  assign accept = stable_cnt == 8'(DEBOUNCE_CYCLES) && s_data == prev_data && s_data != data_out;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      d1         <= '0;
      s_data     <= '0;
      prev_data  <= '0;
      stable_cnt <= 8'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      d1         <= data_raw;
      s_data     <= d1;
      prev_data  <= s_data;
      stable_cnt <= s_data != prev_data ? 8'd1 :
                    stable_cnt == 8'(DEBOUNCE_CYCLES) ? stable_cnt : stable_cnt + 8'd1;
      data_out   <= accept ? s_data : data_out;
      data_valid <= accept;
    end
endmodule

// File: tb/tb_traffic_request_conditioner.sv
// tb_traffic_request_conditioner: scoreboard bench with a run-length reference model of the conditioner.
module tb_traffic_request_conditioner;
  localparam int DW = 8, D = 4, C = 8, T = 64;
  logic clk = 1'b0, reset = 1'b1;
  logic ped_raw = 1'b0, em_raw = 1'b0, ped_ack = 1'b0, em_ack = 1'b0;
  logic [DW-1:0] data_raw = '0;
  logic ped_req, em_req, data_valid;
  logic [DW-1:0] data_out;
  logic [1:0] req_timeout;
  int checks = 0, errors = 0, cyc = 0;
  bit auto_ack = 0;
  longint ped_q[$], em_q[$], dq[$];
  logic [1:0] exp_to = 2'b00;
  bit bh[2][3];
  logic [DW-1:0] dh[D+3];
  logic [DW-1:0] mdata;
  int mst[2], hi[2], pn[2], cs[2];
  bit pv_p, pv_e;
  always #5 clk = ~clk;
  traffic_request_conditioner dut (
    .clk(clk), .reset(reset), .ped_raw(ped_raw), .em_raw(em_raw), .data_raw(data_raw),
    .ped_ack(ped_ack), .em_ack(em_ack), .ped_req(ped_req), .em_req(em_req),
    .data_out(data_out), .data_valid(data_valid), .req_timeout(req_timeout)
  );
  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic push_ev(input int c, input longint v);
    if (c == 1) em_q.push_back(v);
    else ped_q.push_back(v);
  endtask
  task automatic model_reset();
    cyc = 0;
    exp_to = 2'b00;
    mdata = '0;
    for (int i = 0; i < D + 3; i++) dh[i] = '0;
    for (int c = 0; c < 2; c++) begin
      mst[c] = 0; hi[c] = 0; pn[c] = 0; cs[c] = 0;
      for (int i = 0; i < 3; i++) bh[c][i] = 0;
    end
  endtask
  // Button model: idle run of D+1 synchronized highs raises req; ack or timeout drops it;
  // re-arm needs C edges since the drop and a released button.
  task automatic chan_step(input int c, input bit a);
    bit s;
    s = bh[c][2];
    if (mst[c] == 0) begin
      hi[c] = s ? hi[c] + 1 : 0;
      if (hi[c] == D + 1) begin
        mst[c] = 1; pn[c] = 0;
        push_ev(c, longint'(cyc) * 2 + 1);
      end
    end else if (mst[c] == 1) begin
      pn[c]++;
      if (a) begin
        mst[c] = 2; cs[c] = cyc;
        push_ev(c, longint'(cyc) * 2);
      end
`ifdef REQ_TIMEOUT_EN
      else if (pn[c] == T) begin
        mst[c] = 2; cs[c] = cyc;
        push_ev(c, longint'(cyc) * 2);
        exp_to[c] = 1'b1;
      end
`endif
    end else if (cyc >= cs[c] + C && !s) begin
      mst[c] = 0; hi[c] = 0;
    end
  endtask
  task automatic model_step();
    bit ok;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    exp_to = 2'b00;
    for (int c = 0; c < 2; c++) begin
      bh[c][2] = bh[c][1];
      bh[c][1] = bh[c][0];
      bh[c][0] = c == 1 ? em_raw : ped_raw;
      chan_step(c, c == 1 ? em_ack : ped_ack);
    end
    for (int i = D + 2; i > 0; i--) dh[i] = dh[i-1];
    dh[0] = data_raw;
    ok = 1;
    for (int i = 3; i <= D + 2; i++) if (dh[i] != dh[2]) ok = 0;
    if (ok && dh[2] != mdata) begin
      mdata = dh[2];
      dq.push_back(longint'(cyc) * 256 + longint'(dh[2]));
    end
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end
  initial begin
    pv_p = 0; pv_e = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv_p = 0; pv_e = 0;
      end else begin
        if (ped_req !== pv_p) begin
          if (ped_q.size() == 0) check("ped_req_unexpected", longint'(cyc) * 2 + ped_req, -1);
          else check("ped_req_edge", longint'(cyc) * 2 + ped_req, ped_q.pop_front());
          pv_p = ped_req;
        end
        if (em_req !== pv_e) begin
          if (em_q.size() == 0) check("em_req_unexpected", longint'(cyc) * 2 + em_req, -1);
          else check("em_req_edge", longint'(cyc) * 2 + em_req, em_q.pop_front());
          pv_e = em_req;
        end
        if (data_valid === 1'b1) begin
          if (dq.size() == 0) check("data_valid_unexpected", longint'(data_out), -1);
          else check("data_pulse", longint'(cyc) * 256 + longint'(data_out), dq.pop_front());
        end
        check("req_timeout", longint'(req_timeout), longint'(exp_to));
      end
    end
  end
  initial
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        ped_ack = ped_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0;
        em_ack  = em_req  ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0;
      end
    end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_req(input bit em, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (em ? em_req : ped_req) ok = 1;
      else @(negedge clk);
    end
    check(name, ok, 1);
  endtask
  task automatic pulse_ack(input bit em);
    if (em) em_ack = 1; else ped_ack = 1;
    tick(1);
    em_ack = 0; ped_ack = 0;
  endtask
  initial begin
    data_raw = 8'd2;
    tick(3);
    check("rst_ped_req", ped_req, 0);
    check("rst_em_req", em_req, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_req_timeout", req_timeout, 0);
    reset = 0;
    tick(20);
    check("data_after_reset", data_out, 2);
    ped_raw = 1; tick(1); ped_raw = 0; tick(15);
    ped_raw = 1; tick(10); ped_raw = 0;
    wait_req(0, "ped_req_wait");
    tick(3); pulse_ack(0); tick(15);
    em_raw = 1;
    wait_req(1, "em_req_wait");
    tick(2); pulse_ack(1); tick(20);
    em_raw = 0; tick(C + 5);
    em_raw = 1; tick(8); em_raw = 0;
    wait_req(1, "em_req_second");
    pulse_ack(1); tick(15);
    ped_raw = 1; em_raw = 1; tick(8); ped_raw = 0; em_raw = 0;
    wait_req(1, "both_em_wait");
    tick(1); pulse_ack(1); tick(5);
    check("ped_held_after_em_ack", ped_req, 1);
    pulse_ack(0); tick(15);
    data_raw = 8'd10; tick(2);
    data_raw = 8'd0;  tick(2);
    data_raw = 8'd5;  tick(2);
    data_raw = 8'd20; tick(15);
    check("data_settled", data_out, 20);
    ped_raw = 1; tick(8); ped_raw = 0;
    tick(T + 10); pulse_ack(0); tick(15);
    auto_ack = 1;
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) ped_raw = ~ped_raw;
      if ($urandom_range(0, 9) == 0) em_raw = ~em_raw;
      if ($urandom_range(0, 11) == 0) data_raw = DW'($urandom_range(0, 255));
    end
    ped_raw = 0; em_raw = 0; tick(40);
    auto_ack = 0; ped_ack = 0; em_ack = 0; tick(20);
    ped_raw = 1;
    wait_req(0, "ped_req_before_reset");
    #2 reset = 1;
    #1 check("async_reset_ped_req", ped_req, 0);
    check("async_reset_data_out", data_out, 0);
    tick(3); ped_raw = 0;
    reset = 0;
    tick(20);
    check("ped_q_empty", ped_q.size(), 0);
    check("em_q_empty", em_q.size(), 0);
    check("data_q_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
